// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder_gate between two requesters.
// Single outstanding transaction: accept -> drive adder -> hold response.
module adder_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH:0]   rsp0_sum,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH:0]   rsp1_sum,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_carry,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             idle;
  logic             accept;
  logic             rsp_take;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH:0]   result;

  assign idle = (state == IDLE);

  // Grant: a lone requester wins; on a tie, whoever was not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = idle & req0_valid & ~grant;
  assign req1_ready = idle & req1_valid & grant;
  assign accept     = req0_ready | req1_ready;
  assign rsp_take   = (state == RESP) &
                      (owner ? rsp1_ready : rsp0_ready);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one compute cycle, then hold until the owner takes it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = COMPUTE;
      COMPUTE: state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, result capture and completion bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_x       <= '0;
      op_y       <= '0;
      result     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      done_cnt   <= '0;
    end else begin
      if (accept) begin
        op_x  <= grant ? req1_x : req0_x;
        op_y  <= grant ? req1_y : req0_y;
        owner <= grant;
      end
      if (state == COMPUTE) begin
        result <= {add_carry, add_out};
      end
      if (rsp_take) begin
        last_grant <= owner;
        if (done_cnt != {CNT_W{1'b1}}) begin
          done_cnt <= done_cnt + 1'b1;
        end
      end
    end
  end

  assign add_x      = op_x;
  assign add_y      = op_y;
  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;
  assign rsp0_sum   = result;
  assign rsp1_sum   = result;
  assign busy       = ~idle;

endmodule
